// File: rtl/huffman_decoder_if.sv
// Serial code-bit input and decoded-byte output bundle for huffman_decoder.
// The master side is the bitstream source/byte consumer; the slave side is the decoder.
interface huffman_decoder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_in;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_out,
    input  data_out_valid,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_out,
    output data_out_valid,
    output busy
  );
endinterface

// File: rtl/huffman_decoder.sv
// Serial decoder for a two-class prefix code: '0' -> ZERO_SYMBOL,
// '1' + DATA_WIDTH payload bits (MSB first) -> literal byte.
module huffman_decoder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] ZERO_SYMBOL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  huffman_decoder_if.slave         bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    LITERAL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_out_valid_q, data_out_valid_d;
  logic                  busy_q, busy_d;

  logic                  last_bit;
  logic [DATA_WIDTH-1:0] shifted;

  assign last_bit = (cnt_q == LAST_CNT);
  // Truncating cast drops the old MSB so the first payload bit lands in the MSB.
  assign shifted  = DATA_WIDTH'({shift_q, bus.data_in});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      shift_q          <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      shift_q          <= shift_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      busy_q           <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.data_valid) begin
      unique case (state_q)
        IDLE:    if (bus.data_in) state_d = LITERAL;
        LITERAL: if (last_bit)    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d            = cnt_q;
    shift_d          = shift_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    if (bus.data_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.data_in) begin
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            data_out_d       = ZERO_SYMBOL;
            data_out_valid_d = 1'b1;
          end
        end
        LITERAL: begin
          shift_d = shifted;
          if (last_bit) begin
            cnt_d            = '0;
            data_out_d       = shifted;
            data_out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          shift_d = '0;
        end
      endcase
    end
    busy_d = (state_d == LITERAL);
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: directed code streams plus randomized
// bits/gaps against a bit-queue reference model.
module tb_huffman_decoder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  bit   started;

  exp_t   exp_q[$];
  bit     m_bits[$];
  bit     m_lit;
  logic [W-1:0] m_last;

  huffman_decoder_if #(.DATA_WIDTH(W)) bus ();

  huffman_decoder #(
    .DATA_WIDTH (W),
    .ZERO_SYMBOL(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one call per accepted bit; the result becomes visible one cycle later.
  task automatic model_bit(input bit b);
    exp_t e;
    logic [W-1:0] v;
    if (!m_lit) begin
      if (b) begin
        m_lit = 1'b1;
        m_bits.delete();
      end else begin
        e.d = 8'h00;
        e.c = cyc + 1;
        exp_q.push_back(e);
      end
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        v = '0;
        for (int i = 0; i < W; i++) if (m_bits[i]) v = v + (W'(1) << (W - 1 - i));
        e.d = v;
        e.c = cyc + 1;
        exp_q.push_back(e);
        m_lit = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  task automatic send(input bit b, input bit v);
    @(negedge clk);
    bus.data_valid = v;
    bus.data_in    = v ? b : 1'($urandom_range(0, 1));
    if (v && reset) model_bit(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "0") send(1'b0, 1'b1);
      else if (s[i] == "1") send(1'b1, 1'b1);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset          = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = 1'($urandom_range(0, 1));
    m_lit  = 1'b0;
    m_bits.delete();
    exp_q.delete();
    m_last = '0;
    started = 1'b1;
    #1;
    chk("reset_async_busy", 32'(bus.busy), 32'd0);
    chk("reset_async_valid", 32'(bus.data_out_valid), 32'd0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      bus.data_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
    reset          = 1'b1;
  endtask

  // Monitor: checks outputs just after every rising edge against the scoreboard.
  initial begin
    bit   exp_v;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (!reset) begin
          chk("rst_data_out", 32'(bus.data_out), 32'd0);
          chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
          chk("rst_busy", 32'(bus.busy), 32'd0);
        end else begin
          exp_v = (exp_q.size() > 0) && (exp_q[0].c == cyc);
          chk("out_valid", 32'(bus.data_out_valid), 32'(exp_v));
          if (exp_v) begin
            e = exp_q.pop_front();
            m_last = e.d;
          end
          chk("data_out", 32'(bus.data_out), 32'(m_last));
          chk("busy", 32'(bus.busy), 32'(m_lit));
        end
      end
    end
  end

  initial begin
    int r;
    reset          = 1'b1;
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    started  = 1'b0;
    m_lit    = 1'b0;
    m_last   = '0;

    do_reset(6);
    send_str("0 101010000 0 110100000 0 0 100000101 0");
    gap(3);
    send_str("111111111 100000000 110000000 100000001");
    gap(2);
    send_str("1 0111");
    gap(5);
    send_str("1111");
    gap(2);
    send_str("1 101");
    do_reset(1);
    send_str("0");
    gap(2);
    send_str("1 1010101");
    gap(20);
    send_str("1");
    gap(2);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      send(1'($urandom_range(0, 1)), r < 7);
      if (i == 1500) do_reset(2);
    end
    gap(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Serial-input decoder for a two-class prefix code. Consumes one bit per valid clock and emits decoded bytes.
- Code `0` (1 bit) decodes to the zero symbol 0x00.
- Code `1` followed by 8 payload bits, MSB first (9 bits total), decodes to the literal payload byte.
- Sits between a serial bitstream source and a byte-wide consumer; there is no backpressure.

Parameters:
- DATA_WIDTH, 8, literal payload width in bits and width of data_out.
- ZERO_SYMBOL, 8'h00, value emitted for a `0` code (width DATA_WIDTH).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- data_in  input  1  serial code bit, sampled on rising clk when data_valid=1.
- data_valid  input  1  qualifies data_in; when 0 the bit is ignored and all state holds.
- data_out  output  DATA_WIDTH  decoded symbol; registered.
- data_out_valid  output  1  one-cycle pulse marking a new symbol on data_out.
- busy  output  1  high while a literal is partially received (prefix `1` seen, payload incomplete).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_out_valid=0, busy=0.
  - Any partial literal is discarded.
  - Decoding restarts with the first valid bit after reset deasserts.
- Two-state FSM, IDLE and LITERAL, with a bit counter of 0..DATA_WIDTH-1 and a DATA_WIDTH-bit shift register.
- IDLE, valid bit:
  - data_in=0: data_out<=ZERO_SYMBOL, data_out_valid<=1, stay IDLE.
  - data_in=1: go to LITERAL, counter<=0, shift register cleared, data_out_valid<=0.
- LITERAL, valid bit:
  - Shift data_in into the LSB; earlier bits move toward the MSB (first payload bit ends up in the MSB).
  - Counter increments on each valid bit.
  - On the DATA_WIDTH-th payload bit: data_out<={shift[DATA_WIDTH-2:0], data_in}, data_out_valid<=1, return to IDLE.
- Latency: data_out/data_out_valid update on the same rising edge that samples the final bit of a codeword. They are visible in the following cycle.
- data_out_valid:
  - Is 1 for exactly one cycle per decoded symbol.
  - Is 0 on any cycle whose edge did not complete a codeword, including data_valid=0 cycles.
- data_out holds its last decoded value until the next symbol completes.
- busy:
  - Registered; equals 1 exactly when state=LITERAL.
  - Rises the cycle after the prefix `1` is sampled.
  - Falls on the edge that samples the last payload bit.
- data_valid=0 in any state:
  - Freezes state, counter and shift register.
  - A literal may be split across arbitrary gaps and still decodes correctly.
- Back-to-back codewords need no idle bits: `0` codes can produce a symbol every cycle. A literal produces one symbol per 9 valid cycles.
- A literal left incomplete at end of stream stays pending; busy=1 and nothing is emitted until more bits arrive or reset.
- data_in is ignored (don't-care) when data_valid=0.

Test Plan:
- Reset check: hold reset=0 with random data_in/data_valid=1 -> data_out=0x00, data_out_valid=0, busy=0 throughout. Release reset -> first valid bit starts decoding.
- Continuous stream, data_valid=1, bits `0 101010000 0 110100000 0 0 100000101 0` -> valid pulses in order 0x00, 0x50, 0x00, 0xA0, 0x00, 0x00, 0x05, 0x00. Each pulse lands one cycle after the codeword's last bit. busy is high for exactly 8 cycles per literal.
- Boundary literals `1 11111111`, `1 00000000`, `1 10000000`, `1 00000001` -> 0xFF, 0x00, 0x80, 0x01. Bit ordering must be MSB first.
- Gapped literal: send `1 0111` with data_valid=1, drop data_valid for 5 cycles, then send `1111` -> single pulse 0x7F. No pulse during the gap; busy stays 1 across the gap.
- Reset mid-literal: send `1 101`, assert reset for 1 cycle, then send `0` -> busy drops immediately and a single 0x00 pulse follows. No stale literal is emitted.
- Trailing partial: send `1` + 7 bits then hold data_valid=0 for 20 cycles -> busy=1 and no data_out_valid. The 8th bit then completes the byte.
